// File: rtl/mem_responder.sv
// Single-ported line memory that serves one instruction/data request at a time.
// Round-robin arbitration, fixed accept-to-fill latency, shared response buses.
module mem_responder #(
  parameter int unsigned MEM_LATENCY      = 5,
  parameter int unsigned MEM_LINES        = 1024,
  parameter int unsigned ADDRESS_WIDTH    = 32,
  parameter int unsigned CACHE_LINE_WIDTH = 128
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_req_in,
  input  logic [ADDRESS_WIDTH-1:0]    i_req_addr_in,
  input  logic [CACHE_LINE_WIDTH-1:0] i_req_data_in,
  input  logic                        i_req_write_in,
  output logic                        i_grant_out,
  output logic                        i_fill_out,
  input  logic                        d_req_in,
  input  logic [ADDRESS_WIDTH-1:0]    d_req_addr_in,
  input  logic [CACHE_LINE_WIDTH-1:0] d_req_data_in,
  input  logic                        d_req_write_in,
  output logic                        d_grant_out,
  output logic                        d_fill_out,
  output logic [CACHE_LINE_WIDTH-1:0] fill_data_out,
  output logic [ADDRESS_WIDTH-1:0]    fill_addr_out
);

  localparam int unsigned OffW = $clog2(CACHE_LINE_WIDTH / 8);
  localparam int unsigned IdxW = $clog2(MEM_LINES);
  localparam logic [7:0]  LatM1 = 8'(MEM_LATENCY - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic                        last_q, last_d;  // 1: data port served last
  logic                        port_q, port_d;  // 1: data port is being served
  logic [ADDRESS_WIDTH-1:0]    addr_q, addr_d;
  logic [CACHE_LINE_WIDTH-1:0] data_q, data_d;
  logic                        write_q, write_d;
  logic                        i_grant_q, i_grant_d;
  logic                        d_grant_q, d_grant_d;
  logic [CACHE_LINE_WIDTH-1:0] fill_data_q, fill_data_d;
  logic [ADDRESS_WIDTH-1:0]    fill_addr_q, fill_addr_d;
  logic                        mem_we;
  logic                        pick_d;
  logic [IdxW-1:0]             idx;

  // Zero at power-up; deliberately untouched by reset.
  logic [CACHE_LINE_WIDTH-1:0] mem_q [MEM_LINES] = '{default: '0};

  assign idx = addr_q[OffW +: IdxW];
  // Data port wins unless the instruction port is also asking and data went last.
  assign pick_d = d_req_in && (!i_req_in || !last_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    port_d      = port_q;
    addr_d      = addr_q;
    data_d      = data_q;
    write_d     = write_q;
    i_grant_d   = 1'b0;
    d_grant_d   = 1'b0;
    fill_data_d = fill_data_q;
    fill_addr_d = fill_addr_q;
    mem_we      = 1'b0;
    case (state_q)
      StIdle: begin
        if (i_req_in || d_req_in) begin
          state_d   = StBusy;
          cnt_d     = LatM1;
          port_d    = pick_d;
          last_d    = pick_d;
          addr_d    = pick_d ? d_req_addr_in  : i_req_addr_in;
          data_d    = pick_d ? d_req_data_in  : i_req_data_in;
          write_d   = pick_d ? d_req_write_in : i_req_write_in;
          i_grant_d = !pick_d;
          d_grant_d = pick_d;
        end
      end
      StBusy: begin
        if (cnt_q == 8'd1) begin
          state_d     = StResp;
          mem_we      = write_q;
          fill_data_d = write_q ? data_q : mem_q[idx];
          fill_addr_d = addr_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      port_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      write_q     <= 1'b0;
      i_grant_q   <= 1'b0;
      d_grant_q   <= 1'b0;
      fill_data_q <= '0;
      fill_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      port_q      <= port_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      write_q     <= write_d;
      i_grant_q   <= i_grant_d;
      d_grant_q   <= d_grant_d;
      fill_data_q <= fill_data_d;
      fill_addr_q <= fill_addr_d;
    end
  end

  // A reset on the commit edge discards the write.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      mem_q[idx] <= data_q;
    end
  end

  assign i_grant_out   = i_grant_q;
  assign d_grant_out   = d_grant_q;
  assign i_fill_out    = (state_q == StResp) && !port_q;
  assign d_fill_out    = (state_q == StResp) && port_q;
  assign fill_data_out = fill_data_q;
  assign fill_addr_out = fill_addr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized bench for mem_responder against a transaction-timeline reference model.
module tb_mem_responder;
  localparam int unsigned L     = 5;
  localparam int unsigned LINES = 1024;
  localparam int unsigned AW    = 32;
  localparam int unsigned LW    = 128;
  localparam int unsigned LBYTES = LW / 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_req_in = 1'b0, d_req_in = 1'b0;
  logic [AW-1:0] i_req_addr_in = '0, d_req_addr_in = '0;
  logic [LW-1:0] i_req_data_in = '0, d_req_data_in = '0;
  logic          i_req_write_in = 1'b0, d_req_write_in = 1'b0;
  logic          i_grant_out, i_fill_out, d_grant_out, d_fill_out;
  logic [LW-1:0] fill_data_out;
  logic [AW-1:0] fill_addr_out;

  always #5 clk = ~clk;

  mem_responder #(
    .MEM_LATENCY(L), .MEM_LINES(LINES), .ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(LW)
  ) dut (
    .clk(clk), .reset(reset),
    .i_req_in(i_req_in), .i_req_addr_in(i_req_addr_in), .i_req_data_in(i_req_data_in),
    .i_req_write_in(i_req_write_in), .i_grant_out(i_grant_out), .i_fill_out(i_fill_out),
    .d_req_in(d_req_in), .d_req_addr_in(d_req_addr_in), .d_req_data_in(d_req_data_in),
    .d_req_write_in(d_req_write_in), .d_grant_out(d_grant_out), .d_fill_out(d_fill_out),
    .fill_data_out(fill_data_out), .fill_addr_out(fill_addr_out)
  );

  // Reference model: one outstanding transaction with an accept edge, memory as an array.
  logic [LW-1:0] mem_m [LINES];
  bit            pend, pend_port, pend_w, last_m;
  logic [AW-1:0] pend_a;
  logic [LW-1:0] pend_dat;
  int            acc_e, free_at, edge_n;
  logic [LW-1:0] cur_fd;
  logic [AW-1:0] cur_fa;
  bit            e_ig, e_dg, e_if, e_df;
  int            n_total = 0, n_bad = 0;

  localparam logic [LW-1:0] PatA5 = {16{8'hA5}};

  function automatic int unsigned line_of(input logic [AW-1:0] a);
    return (a / LBYTES) % LINES;
  endfunction

  task automatic check_val(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s edge=%0d got=%h exp=%h", tag, edge_n, got, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit ir, input logic [AW-1:0] ia, input bit iw,
                            input logic [LW-1:0] idat, input bit dr, input logic [AW-1:0] da,
                            input bit dw, input logic [LW-1:0] ddat);
    bit pick;
    e_ig = 0; e_dg = 0; e_if = 0; e_df = 0;
    if (rst) begin
      pend = 0; last_m = 0; cur_fd = '0; cur_fa = '0; free_at = edge_n + 1;
    end else if (pend && edge_n == acc_e + int'(L) - 1) begin
      if (pend_w) mem_m[line_of(pend_a)] = pend_dat;
      cur_fd = pend_w ? pend_dat : mem_m[line_of(pend_a)];
      cur_fa = pend_a;
      if (pend_port) e_df = 1; else e_if = 1;
      pend = 0;
      free_at = acc_e + int'(L) + 1;
    end else if (!pend && edge_n >= free_at && (ir || dr)) begin
      pick = dr && (!ir || !last_m);
      last_m = pick; pend = 1; pend_port = pick; acc_e = edge_n;
      pend_a = pick ? da : ia; pend_dat = pick ? ddat : idat; pend_w = pick ? dw : iw;
      if (pick) e_dg = 1; else e_ig = 1;
    end
  endtask

  task automatic step(input bit rst, input bit ir, input logic [AW-1:0] ia, input bit iw,
                      input logic [LW-1:0] idat, input bit dr, input logic [AW-1:0] da,
                      input bit dw, input logic [LW-1:0] ddat);
    reset = rst; i_req_in = ir; i_req_addr_in = ia; i_req_write_in = iw; i_req_data_in = idat;
    d_req_in = dr; d_req_addr_in = da; d_req_write_in = dw; d_req_data_in = ddat;
    model_edge(rst, ir, ia, iw, idat, dr, da, dw, ddat);
    @(posedge clk);
    @(negedge clk);
    check_val("i_grant", LW'(i_grant_out), LW'(e_ig));
    check_val("d_grant", LW'(d_grant_out), LW'(e_dg));
    check_val("i_fill", LW'(i_fill_out), LW'(e_if));
    check_val("d_fill", LW'(d_fill_out), LW'(e_df));
    check_val("fill_data", fill_data_out, cur_fd);
    check_val("fill_addr", LW'(fill_addr_out), LW'(cur_fa));
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, '0, 0, '0, 0, '0, 0, '0);
  endtask

  // One request on a single port followed by enough idle cycles to drain it.
  task automatic one_req(input bit dport, input logic [AW-1:0] a, input bit w,
                         input logic [LW-1:0] dat);
    if (dport) step(0, 0, '0, 0, '0, 1, a, w, dat);
    else       step(0, 1, a, w, dat, 0, '0, 0, '0);
    idle(L + 1);
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [AW-1:0] rnd_addr();
    return AW'($urandom_range(0, 7) * LBYTES + $urandom_range(0, 3) * LINES * LBYTES
               + $urandom_range(0, LBYTES - 1));
  endfunction

  initial begin
    for (int k = 0; k < int'(LINES); k++) mem_m[k] = '0;
    pend = 0; last_m = 0; free_at = 0; edge_n = 0; cur_fd = '0; cur_fa = '0;
    @(negedge clk);
    step(1, 1, 32'h10, 0, '0, 1, 32'h20, 0, '0);
    step(1, 0, '0, 0, '0, 0, '0, 0, '0);

    // Plain read of an untouched line.
    one_req(1, 32'h40, 0, '0);
    check_val("read40_data", fill_data_out, '0);
    check_val("read40_addr", LW'(fill_addr_out), LW'(32'h40));

    // Write then read back the same line.
    one_req(1, 32'h80, 1, PatA5);
    check_val("wr80_echo", fill_data_out, PatA5);
    one_req(0, 32'h80, 0, '0);
    check_val("rd80_data", fill_data_out, PatA5);

    // Both ports held high: alternating service.
    for (int k = 0; k < 4 * int'(L + 1); k++)
      step(0, 1, 32'h200 + AW'(k), 0, '0, 1, 32'h300 + AW'(k), 0, '0);
    idle(L + 1);

    // Instruction request raised while the data request is in flight.
    step(0, 0, '0, 0, '0, 1, 32'h50, 0, '0);
    for (int k = 0; k < int'(L + 1); k++) step(0, 1, 32'h60, 0, '0, 0, '0, 0, '0);
    idle(L + 1);

    // Reset three cycles into a write aborts it.
    step(0, 0, '0, 0, '0, 1, 32'h100, 1, rnd_line());
    idle(2);
    step(1, 0, '0, 0, '0, 0, '0, 0, '0);
    idle(L + 2);
    one_req(1, 32'h100, 0, '0);
    check_val("rst_abort_rd", fill_data_out, '0);

    // Aliasing modulo the number of lines.
    one_req(1, 32'h40 + AW'(LINES * LBYTES), 1, {4{32'hCAFE_F00D}});
    one_req(1, 32'h40, 0, '0);
    check_val("alias_rd", fill_data_out, {4{32'hCAFE_F00D}});

    // Random traffic with occasional resets.
    for (int k = 0; k < 2000; k++)
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 2) == 0, rnd_addr(), 1'($urandom_range(0, 1)), rnd_line(),
           $urandom_range(0, 2) == 0, rnd_addr(), 1'($urandom_range(0, 1)), rnd_line());
    idle(L + 2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
